// File: rtl/cobs_decode_if.sv
// ----------------------------------------------------------------------------
// cobs_decode_if
// Byte-wide AXI-Stream style link used on both sides of the COBS decoder.
//   tdata  : 8-bit byte
//   tvalid : byte valid (master -> slave)
//   tready : sink ready (slave -> master)
//   tlast  : last byte of frame
//   tuser  : sideband flag (error marker on the decoded side)
// Modports: master drives data/valid/last/user, slave drives ready.
// ----------------------------------------------------------------------------
interface cobs_decode_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser,
                   input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser,
                   output tready);
endinterface

// File: rtl/cobs_decode.sv
// ----------------------------------------------------------------------------
// cobs_decode
// Streaming COBS decoder, one byte per cycle. Encoded frames are delimited by
// 0x00 on the input stream; decoded payload bytes leave with tlast on the
// final byte of each frame and tuser set when the frame was truncated.
// Ports:
//   clk         : single clock
//   rst_n       : asynchronous active-low reset
//   s           : encoded input stream (slave); s.tlast/s.tuser are ignored
//   m           : decoded output stream (master); m.tuser qualified by m.tlast
//   frame_error : one-cycle pulse when a group is cut short by a 0x00
// ----------------------------------------------------------------------------
module cobs_decode (
   input  logic          clk,
   input  logic          rst_n,
   cobs_decode_if.slave  s,
   cobs_decode_if.master m,
   output logic          frame_error
);

   typedef enum logic [1:0] {
      FRAME_START,
      GROUP_DATA,
      GROUP_BOUNDARY
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] remaining_q, remaining_d;
   logic       code_ff_q, code_ff_d;
   logic       hold_valid_q, hold_valid_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       m_tvalid_q, m_tvalid_d;
   logic [7:0] m_tdata_q, m_tdata_d;
   logic       m_tlast_q, m_tlast_d;
   logic       m_tuser_q, m_tuser_d;
   logic       frame_error_q, frame_error_d;

   logic       accept;
   logic       is_zero;
   logic       push;
   logic       flush;
   logic       flush_err;
   logic       load;
   logic [7:0] push_byte;

   // Frame boundaries come only from 0x00 in the data.
   logic unused_sideband;
   assign unused_sideband = s.tlast ^ s.tuser;

   // Output register is free when empty or draining this cycle; every
   // accepted byte yields at most one output byte, so this never overflows.
   assign s.tready = !m_tvalid_q || m.tready;
   assign accept   = s.tvalid && s.tready;
   assign is_zero  = (s.tdata == 8'h00);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FRAME_START;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      if (accept) begin
         case (state_q)
            FRAME_START: begin
               if (!is_zero)
                  state_d = (s.tdata == 8'h01) ? GROUP_BOUNDARY : GROUP_DATA;
            end
            GROUP_DATA: begin
               if (is_zero)
                  state_d = FRAME_START;
               else if (remaining_q == 8'd1)
                  state_d = GROUP_BOUNDARY;
            end
            GROUP_BOUNDARY: begin
               if (is_zero)
                  state_d = FRAME_START;
               else
                  state_d = (s.tdata == 8'h01) ? GROUP_BOUNDARY : GROUP_DATA;
            end
            default: state_d = FRAME_START;
         endcase
      end
   end

   // ---------------- action decode ----------------
   always_comb begin
      push      = 1'b0;
      flush     = 1'b0;
      flush_err = 1'b0;
      load      = 1'b0;
      push_byte = s.tdata;
      if (accept) begin
         case (state_q)
            FRAME_START: begin
               load = !is_zero;
            end
            GROUP_DATA: begin
               if (is_zero) begin
                  flush     = 1'b1;
                  flush_err = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
            GROUP_BOUNDARY: begin
               if (is_zero) begin
                  flush = 1'b1;
               end else begin
                  // A 0xFF group carries no implied zero after it.
                  load      = 1'b1;
                  push      = !code_ff_q;
                  push_byte = 8'h00;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      remaining_d   = remaining_q;
      code_ff_d     = code_ff_q;
      hold_valid_d  = hold_valid_q;
      hold_data_d   = hold_data_q;
      m_tvalid_d    = m_tvalid_q;
      m_tdata_d     = m_tdata_q;
      m_tlast_d     = m_tlast_q;
      m_tuser_d     = m_tuser_q;
      frame_error_d = flush_err;

      // A code load wins over the decrement when a boundary push and load
      // happen together.
      if (load) begin
         remaining_d = s.tdata - 8'd1;
         code_ff_d   = (s.tdata == 8'hFF);
      end else if (push) begin
         remaining_d = remaining_q - 8'd1;
      end

      if (push) begin
         hold_valid_d = 1'b1;
         hold_data_d  = push_byte;
      end else if (flush) begin
         hold_valid_d = 1'b0;
      end

      if (m.tready)
         m_tvalid_d = 1'b0;
      if ((push || flush) && hold_valid_q) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = hold_data_q;
         m_tlast_d  = flush;
         m_tuser_d  = flush_err;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining_q   <= '0;
         code_ff_q     <= 1'b0;
         hold_valid_q  <= 1'b0;
         hold_data_q   <= '0;
         m_tvalid_q    <= 1'b0;
         m_tdata_q     <= '0;
         m_tlast_q     <= 1'b0;
         m_tuser_q     <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         remaining_q   <= remaining_d;
         code_ff_q     <= code_ff_d;
         hold_valid_q  <= hold_valid_d;
         hold_data_q   <= hold_data_d;
         m_tvalid_q    <= m_tvalid_d;
         m_tdata_q     <= m_tdata_d;
         m_tlast_q     <= m_tlast_d;
         m_tuser_q     <= m_tuser_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign m.tvalid    = m_tvalid_q;
   assign m.tdata     = m_tdata_q;
   assign m.tlast     = m_tlast_q;
   assign m.tuser     = m_tuser_q;
   assign frame_error = frame_error_q;

endmodule
